// File: rtl/prio_arbiter_seq_if.sv
// Handshake bundle between the request sources, the priority arbiter and its single consumer.
// The arbiter side uses the slave modport; whoever drives requests and accepts grants uses master.
interface prio_arbiter_seq_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    localparam int IDX_W = ($clog2(N) > 1) ? $clog2(N) : 1;

    logic [N-1:0]     req;
    logic             rr_mode;
    logic             grant_ready;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     grant_onehot;
    logic [CNT_W-1:0] grant_count;

    modport master (
        output req,
        output rr_mode,
        output grant_ready,
        input  grant_valid,
        input  grant_idx,
        input  grant_onehot,
        input  grant_count
    );

    modport slave (
        input  req,
        input  rr_mode,
        input  grant_ready,
        output grant_valid,
        output grant_idx,
        output grant_onehot,
        output grant_count
    );
endinterface

// File: rtl/prio_arbiter_seq.sv
// Registered N-input priority arbiter with valid/ready grant handshake and accepted-grant counter.
// Define PRIO_ARB_RR_EN to build the round-robin search and last-grant pointer; otherwise fixed priority only.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant pending, grant_valid = 0, arbitrating every edge
//   HOLD  | grant pending and frozen until grant_valid & grant_ready
module prio_arbiter_seq #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    prio_arbiter_seq_if.slave  bus
);
    localparam int IDX_W = ($clog2(N) > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic [N-1:0]     grant_onehot_q;
    logic [CNT_W-1:0] grant_count_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;

`ifdef PRIO_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] arb_base;
    int               rr_pos;

    // On acceptance the pointer is about to become grant_idx, so search from there already.
    assign arb_base = (state_q == HOLD) ? grant_idx_q : ptr_q;
`else
    logic unused_rr_mode;
    assign unused_rr_mode = bus.rr_mode;
`endif

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef PRIO_ARB_RR_EN
        rr_pos    = 0;
        if (bus.rr_mode) begin
            // Ascending search starting just after the last winner, wrapping at N.
            for (int k = 0; k < N; k++) begin
                rr_pos = int'(arb_base) + 1 + k;
                if (rr_pos >= N) begin
                    rr_pos = rr_pos - N;
                end
                if (!win_found && (|(bus.req & (LSB_ONE << rr_pos)))) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(rr_pos);
                end
            end
        end else
`endif
        begin
            for (int i = 0; i < N; i++) begin
                if (|(bus.req & (LSB_ONE << i))) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            grant_count_q  <= '0;
`ifdef PRIO_ARB_RR_EN
            ptr_q          <= IDX_W'(N - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q        <= HOLD;
                        grant_idx_q    <= win_idx;
                        grant_onehot_q <= LSB_ONE << win_idx;
                    end
                end
                HOLD: begin
                    if (bus.grant_ready) begin
                        grant_count_q <= grant_count_q + CNT_W'(1);
`ifdef PRIO_ARB_RR_EN
                        ptr_q         <= grant_idx_q;
`endif
                        if (win_found) begin
                            grant_idx_q    <= win_idx;
                            grant_onehot_q <= LSB_ONE << win_idx;
                        end else begin
                            state_q        <= IDLE;
                            grant_onehot_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    grant_onehot_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant_valid  = (state_q == HOLD);
    assign bus.grant_idx    = grant_idx_q;
    assign bus.grant_onehot = grant_onehot_q;
    assign bus.grant_count  = grant_count_q;

    a_onehot_matches_idx: assert property (@(posedge clk) disable iff (rst)
        bus.grant_valid |-> (bus.grant_onehot == (LSB_ONE << bus.grant_idx)));

    a_onehot_clear_when_idle: assert property (@(posedge clk) disable iff (rst)
        !bus.grant_valid |-> (bus.grant_onehot == '0));

    a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
        bus.grant_valid |-> (int'(bus.grant_idx) < N));
endmodule

// File: tb/tb_prio_arbiter_seq.sv
// Directed bench for prio_arbiter_seq: an N=8 instance for the main handshake and an N=5,
// CNT_W=4 instance for the non-power-of-two round-robin wrap and the counter wrap.
module tb_prio_arbiter_seq;
    logic clk;
    logic rst;
    logic rst5;

    int n_checks;
    int n_fail;

    prio_arbiter_seq_if #(.N(8), .CNT_W(16)) if8 ();
    prio_arbiter_seq_if #(.N(5), .CNT_W(4))  if5 ();

    prio_arbiter_seq #(.N(8), .CNT_W(16)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    prio_arbiter_seq #(.N(5), .CNT_W(4)) dut5 (
        .clk (clk),
        .rst (rst5),
        .bus (if5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  req;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_idx;
        logic [7:0]  exp_onehot;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk8(input string tag, input logic v, input logic [2:0] idx,
                        input logic [7:0] oh, input logic [15:0] cnt);
        chk({tag, ".valid"},  32'(if8.grant_valid),  32'(v));
        chk({tag, ".idx"},    32'(if8.grant_idx),    32'(idx));
        chk({tag, ".onehot"}, 32'(if8.grant_onehot), 32'(oh));
        chk({tag, ".count"},  32'(if8.grant_count),  32'(cnt));
    endtask

    initial begin
        logic [2:0] rr_exp [6];
        logic [2:0] exp_i;
        logic [3:0] exp_c5;
        logic [2:0] exp_i5;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{8'h24, 1'b1, 1'b1, 3'd5, 8'h20, 16'd1};
        vecs[1]  = '{8'h24, 1'b1, 1'b1, 3'd5, 8'h20, 16'd2};
        vecs[2]  = '{8'h24, 1'b1, 1'b1, 3'd5, 8'h20, 16'd3};
        vecs[3]  = '{8'h00, 1'b1, 1'b0, 3'd5, 8'h00, 16'd4};
        vecs[4]  = '{8'h01, 1'b0, 1'b1, 3'd0, 8'h01, 16'd4};
        vecs[5]  = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 16'd4};
        vecs[6]  = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 16'd4};
        vecs[7]  = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 16'd4};
        vecs[8]  = '{8'h00, 1'b0, 1'b1, 3'd0, 8'h01, 16'd4};
        vecs[9]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 16'd5};
        vecs[10] = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 16'd5};
        vecs[11] = '{8'h81, 1'b0, 1'b1, 3'd7, 8'h80, 16'd5};
        vecs[12] = '{8'h81, 1'b1, 1'b1, 3'd7, 8'h80, 16'd6};
        vecs[13] = '{8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 16'd7};

`ifdef PRIO_ARB_RR_EN
        rr_exp = '{3'd1, 3'd3, 3'd7, 3'd1, 3'd3, 3'd7};
`else
        rr_exp = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif

        rst             = 1'b1;
        rst5            = 1'b1;
        if8.req         = 8'hFF;
        if8.rr_mode     = 1'b0;
        if8.grant_ready = 1'b0;
        if5.req         = 5'b10001;
        if5.rr_mode     = 1'b1;
        if5.grant_ready = 1'b1;

        @(negedge clk);
        step();
        chk8("reset", 1'b0, 3'd0, 8'h00, 16'd0);

        rst = 1'b0;
        step();
        chk8("first_grant", 1'b1, 3'd7, 8'h80, 16'd0);

        for (int v = 0; v < 14; v++) begin
            if8.req         = vecs[v].req;
            if8.grant_ready = vecs[v].rdy;
            step();
            chk8($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_idx,
                 vecs[v].exp_onehot, vecs[v].exp_count);
        end

        // Round-robin sequence from IDLE with the pointer sitting on 7.
        if8.rr_mode     = 1'b1;
        if8.req         = 8'h8A;
        if8.grant_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_i = rr_exp[c];
            step();
            chk8($sformatf("rr%0d", c), 1'b1, exp_i, 8'h01 << exp_i, 16'(7 + c));
        end

        // Asynchronous reset in the middle of a pending grant.
        #2 rst = 1'b1;
        #1 chk8("async_rst", 1'b0, 3'd0, 8'h00, 16'd0);
        if8.req         = 8'h10;
        if8.rr_mode     = 1'b0;
        if8.grant_ready = 1'b0;
        @(negedge clk);
        step();
        chk8("rst_held", 1'b0, 3'd0, 8'h00, 16'd0);
        rst = 1'b0;
        step();
        chk8("post_rst_grant", 1'b1, 3'd4, 8'h10, 16'd0);

        // N=5 round-robin wrap and 4-bit counter wrap.
        rst5 = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            step();
            exp_c5 = 4'(c - 1);
`ifdef PRIO_ARB_RR_EN
            exp_i5 = (c % 2 == 1) ? 3'd0 : 3'd4;
`else
            exp_i5 = 3'd4;
`endif
            chk($sformatf("n5_valid%0d", c),  32'(if5.grant_valid),  32'd1);
            chk($sformatf("n5_idx%0d", c),    32'(if5.grant_idx),    32'(exp_i5));
            chk($sformatf("n5_onehot%0d", c), 32'(if5.grant_onehot), 32'(5'b00001 << exp_i5));
            chk($sformatf("n5_count%0d", c),  32'(if5.grant_count),  32'(exp_c5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
